// File: rtl/c2n_wrr_service_scheduler_pkg.sv
// Shared service-message types used by the core-to-network service scheduler.
// Holds the message and tile-mask types plus the per-channel weight type and
// the FIFO entry layout that pairs a message with its destination mask.
package c2n_wrr_service_scheduler_pkg;

  localparam int TILE_COUNT            = 16;
  localparam int SERVICE_MESSAGE_WIDTH = 32;
  localparam int C2N_WEIGHT_WIDTH      = 3;

  typedef logic [SERVICE_MESSAGE_WIDTH-1:0] service_message_t;
  typedef logic [TILE_COUNT-1:0]            tile_mask_t;
  typedef logic [C2N_WEIGHT_WIDTH-1:0]      c2n_channel_weight_t;

  typedef struct packed {
    service_message_t message;
    tile_mask_t       mask;
  } c2n_fifo_entry_t;

endpackage

// File: rtl/c2n_wrr_arbiter.sv
// Weighted round-robin arbiter. The current owner keeps the grant while it
// has burst credit and something queued; otherwise the next requester after
// the owner takes over and loads a fresh credit from its weight (0 acts as 1).
module c2n_wrr_arbiter
  import c2n_wrr_service_scheduler_pkg::*;
#(
  parameter int NUM_CHANNELS = 3,
  parameter int WEIGHT_WIDTH = 3,
  localparam int CHANNEL_IDX_W = $clog2(NUM_CHANNELS)
) (
  input  logic                                      clk,
  input  logic                                      reset,
  input  logic [NUM_CHANNELS-1:0]                   request,
  input  logic [NUM_CHANNELS-1:0][WEIGHT_WIDTH-1:0] weight,
  input  logic                                      network_available,
  output logic                                      grant_valid,
  output logic [NUM_CHANNELS-1:0]                   grant,
  output logic [CHANNEL_IDX_W-1:0]                  grant_idx,
  output logic [CHANNEL_IDX_W-1:0]                  owner,
  output logic [WEIGHT_WIDTH-1:0]                   credit
);

  logic                     continue_burst;
  logic [CHANNEL_IDX_W-1:0] switch_idx;
  logic [WEIGHT_WIDTH-1:0]  switch_weight;

  // First requesting channel after 'start', wrapping; reaches 'start' itself last
  function automatic logic [CHANNEL_IDX_W-1:0] first_after(
    input logic [CHANNEL_IDX_W-1:0] start,
    input logic [NUM_CHANNELS-1:0]  req
  );
    logic [CHANNEL_IDX_W-1:0] pick;
    logic [CHANNEL_IDX_W-1:0] cand_idx;
    logic                     found;
    int                       cand;
    pick  = start;
    found = 1'b0;
    for (int k = 1; k <= NUM_CHANNELS; k++) begin
      cand     = (int'(start) + k) % NUM_CHANNELS;
      cand_idx = CHANNEL_IDX_W'(cand);
      if (!found && req[cand_idx]) begin
        pick  = cand_idx;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  // Pick between continuing the owner's burst and switching to the next requester
  always_comb begin
    continue_burst = (credit != '0) && request[owner];
    switch_idx     = first_after(owner, request);
    switch_weight  = weight[switch_idx];
    grant_valid    = network_available && (|request);
    grant_idx      = continue_burst ? owner : switch_idx;
    grant          = '0;
    if (grant_valid) begin
      grant[grant_idx] = 1'b1;
    end
  end

  // Owner/credit advance only on a grant; a switch samples the new owner's weight
  always_ff @(posedge clk) begin
    if (reset) begin
      owner  <= CHANNEL_IDX_W'(NUM_CHANNELS - 1);
      credit <= '0;
    end else if (grant_valid) begin
      if (continue_burst) begin
        credit <= credit - 1'b1;
      end else begin
        owner  <= switch_idx;
        credit <= (switch_weight == '0) ? '0 : switch_weight - 1'b1;
      end
    end
  end

endmodule

// File: rtl/c2n_wrr_service_scheduler.sv
// Core-to-network service scheduler: per-channel FIFOs feeding a weighted
// round-robin arbiter, with a registered output toward the service VN.
// Optional per-channel issue counters are built when C2N_SCHED_STATS_EN is defined.
module c2n_wrr_service_scheduler
  import c2n_wrr_service_scheduler_pkg::*;
#(
  parameter int NUM_CHANNELS          = 3,
  parameter int FIFO_DEPTH            = 4,
  parameter int ALMOST_FULL_THRESHOLD = 2,
  parameter int WEIGHT_WIDTH          = 3
) (
  input  logic                                      clk,
  input  logic                                      reset,
  output logic [NUM_CHANNELS-1:0]                   c2n_network_available,
  input  service_message_t [NUM_CHANNELS-1:0]       c2n_message_out,
  input  logic [NUM_CHANNELS-1:0]                   c2n_message_out_valid,
  input  tile_mask_t [NUM_CHANNELS-1:0]             c2n_destination_valid,
  input  logic [NUM_CHANNELS-1:0][WEIGHT_WIDTH-1:0] channel_weight,
  input  logic                                      network_available,
  output service_message_t                          message_out,
  output logic                                      message_out_valid,
  output tile_mask_t                                destination_valid
`ifdef C2N_SCHED_STATS_EN
  ,
  output logic [NUM_CHANNELS-1:0][31:0]             issue_count
`endif
);

  localparam int CHANNEL_IDX_W = $clog2(NUM_CHANNELS);
  localparam int PTR_W         = $clog2(FIFO_DEPTH);
  localparam int CNT_W         = PTR_W + 1;

  c2n_fifo_entry_t          fifo_mem  [NUM_CHANNELS][FIFO_DEPTH];
  logic [PTR_W-1:0]         wr_ptr    [NUM_CHANNELS];
  logic [PTR_W-1:0]         rd_ptr    [NUM_CHANNELS];
  logic [CNT_W-1:0]         occupancy [NUM_CHANNELS];

  logic [NUM_CHANNELS-1:0]  request;
  logic [NUM_CHANNELS-1:0]  fifo_full;
  logic [NUM_CHANNELS-1:0]  enq_accept;
  logic [NUM_CHANNELS-1:0]  grant;
  logic                     grant_valid;
  logic [CHANNEL_IDX_W-1:0] grant_idx;
  logic [CHANNEL_IDX_W-1:0] arb_owner;
  logic [WEIGHT_WIDTH-1:0]  arb_credit;
  c2n_fifo_entry_t          head_entry;

  // Per-channel status derived from registered occupancy only
  always_comb begin
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      request[i]               = (occupancy[i] != '0);
      fifo_full[i]             = (occupancy[i] == CNT_W'(FIFO_DEPTH));
      enq_accept[i]            = c2n_message_out_valid[i] && (!fifo_full[i] || grant[i]);
      c2n_network_available[i] = (occupancy[i] < CNT_W'(ALMOST_FULL_THRESHOLD));
    end
  end

  c2n_wrr_arbiter #(
    .NUM_CHANNELS (NUM_CHANNELS),
    .WEIGHT_WIDTH (WEIGHT_WIDTH)
  ) u_arbiter (
    .clk               (clk),
    .reset             (reset),
    .request           (request),
    .weight            (channel_weight),
    .network_available (network_available),
    .grant_valid       (grant_valid),
    .grant             (grant),
    .grant_idx         (grant_idx),
    .owner             (arb_owner),
    .credit            (arb_credit)
  );

  // Head of the granted FIFO feeds the output register
  always_comb begin
    head_entry = fifo_mem[grant_idx][rd_ptr[grant_idx]];
  end

  // FIFO pointers and occupancy; a same-cycle push and pop leaves occupancy unchanged
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        wr_ptr[i]    <= '0;
        rd_ptr[i]    <= '0;
        occupancy[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        if (enq_accept[i]) begin
          wr_ptr[i] <= wr_ptr[i] + 1'b1;
        end
        if (grant[i]) begin
          rd_ptr[i] <= rd_ptr[i] + 1'b1;
        end
        if (enq_accept[i] && !grant[i]) begin
          occupancy[i] <= occupancy[i] + 1'b1;
        end else if (!enq_accept[i] && grant[i]) begin
          occupancy[i] <= occupancy[i] - 1'b1;
        end
      end
    end
  end

  // FIFO storage; left unreset since occupancy alone defines what is valid
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      if (!reset && enq_accept[i]) begin
        fifo_mem[i][wr_ptr[i]] <= '{message: c2n_message_out[i], mask: c2n_destination_valid[i]};
      end
    end
  end

  // Registered output toward the VN; data holds between strobes
  always_ff @(posedge clk) begin
    if (reset) begin
      message_out_valid <= 1'b0;
      message_out       <= '0;
      destination_valid <= '0;
    end else begin
      message_out_valid <= grant_valid;
      if (grant_valid) begin
        message_out       <= head_entry.message;
        destination_valid <= head_entry.mask;
      end
    end
  end

`ifdef C2N_SCHED_STATS_EN
  // Free-running per-channel grant counters, cleared only by reset
  always_ff @(posedge clk) begin
    if (reset) begin
      issue_count <= '0;
    end else begin
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        if (grant[i]) begin
          issue_count[i] <= issue_count[i] + 32'd1;
        end
      end
    end
  end
`endif

  // Producers must respect availability; a push into a full, non-draining FIFO is dropped
  for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_overflow_check
    assert property (@(posedge clk) disable iff (reset)
      !(c2n_message_out_valid[i] && fifo_full[i] && !grant[i]));
  end

  // Arbiter state must always name a real channel and a reachable credit
  assert property (@(posedge clk) disable iff (reset)
    (int'(arb_owner) < NUM_CHANNELS) && (int'(arb_credit) < (1 << WEIGHT_WIDTH)));

endmodule

// File: tb/tb_c2n_wrr_service_scheduler.sv
// Testbench for c2n_wrr_service_scheduler: directed scenarios followed by a
// randomized phase, all checked against a queue-based reference model.
// Define C2N_SCHED_STATS_EN to also check the issue counters.
module tb_c2n_wrr_service_scheduler;
  import c2n_wrr_service_scheduler_pkg::*;

  localparam int NC    = 3;
  localparam int DEPTH = 4;
  localparam int THR   = 2;
  localparam int WW    = 3;

  logic                      clk = 1'b0;
  logic                      reset;
  logic [NC-1:0]             c2n_network_available;
  service_message_t [NC-1:0] c2n_message_out;
  logic [NC-1:0]             c2n_message_out_valid;
  tile_mask_t [NC-1:0]       c2n_destination_valid;
  logic [NC-1:0][WW-1:0]     channel_weight;
  logic                      network_available;
  service_message_t          message_out;
  logic                      message_out_valid;
  tile_mask_t                destination_valid;
`ifdef C2N_SCHED_STATS_EN
  logic [NC-1:0][31:0]       issue_count;
`endif

  // Reference model state: plain per-channel queues plus owner/credit integers
  logic [47:0]      mq [NC][$];
  int               m_owner;
  int               m_credit;
  logic             m_valid;
  service_message_t m_msg;
  tile_mask_t       m_mask;
  int               m_issues [NC];
  int               obs [$];

  int pass_count  = 0;
  int check_count = 0;
  int fail_count  = 0;

  c2n_wrr_service_scheduler #(
    .NUM_CHANNELS          (NC),
    .FIFO_DEPTH            (DEPTH),
    .ALMOST_FULL_THRESHOLD (THR),
    .WEIGHT_WIDTH          (WW)
  ) dut (
    .clk                   (clk),
    .reset                 (reset),
    .c2n_network_available (c2n_network_available),
    .c2n_message_out       (c2n_message_out),
    .c2n_message_out_valid (c2n_message_out_valid),
    .c2n_destination_valid (c2n_destination_valid),
    .channel_weight        (channel_weight),
    .network_available     (network_available),
    .message_out           (message_out),
    .message_out_valid     (message_out_valid),
    .destination_valid     (destination_valid)
`ifdef C2N_SCHED_STATS_EN
    ,
    .issue_count           (issue_count)
`endif
  );

  // Free-running clock
  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    check_count++;
    assert (observed === expected) pass_count++;
    else begin
      fail_count++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Advance the model by one cycle using the inputs currently driven
  task automatic model_step();
    int g;
    int c;
    int any;
    logic [WW-1:0] w;
    if (reset) begin
      for (int i = 0; i < NC; i++) begin
        mq[i].delete();
        m_issues[i] = 0;
      end
      m_owner  = NC - 1;
      m_credit = 0;
      m_valid  = 1'b0;
      m_msg    = '0;
      m_mask   = '0;
    end else begin
      any = 0;
      for (int i = 0; i < NC; i++) if (mq[i].size() > 0) any = 1;
      m_valid = 1'b0;
      if (network_available && any != 0) begin
        if (m_credit > 0 && mq[m_owner].size() > 0) begin
          g = m_owner;
          m_credit = m_credit - 1;
        end else begin
          g = -1;
          for (int k = 1; k <= NC; k++) begin
            c = (m_owner + k) % NC;
            if (g < 0 && mq[c].size() > 0) g = c;
          end
          m_owner  = g;
          w        = channel_weight[g];
          m_credit = (w == 0) ? 0 : int'(w) - 1;
        end
        {m_msg, m_mask} = mq[g].pop_front();
        m_valid = 1'b1;
        m_issues[g]++;
      end
      for (int i = 0; i < NC; i++) begin
        if (c2n_message_out_valid[i] && mq[i].size() < DEPTH)
          mq[i].push_back({c2n_message_out[i], c2n_destination_valid[i]});
      end
    end
  endtask

  // One clock: model, edge, sample outputs 1ns later and compare to the model
  task automatic apply_stimulus();
    logic [NC-1:0] exp_avail;
    model_step();
    @(posedge clk);
    #1;
    if (message_out_valid === 1'b1) obs.push_back(int'(message_out[31:24]));
    for (int i = 0; i < NC; i++) exp_avail[i] = (mq[i].size() < THR);
    check_output("valid", 64'(message_out_valid), 64'(m_valid));
    check_output("message", 64'(message_out), 64'(m_msg));
    check_output("mask", 64'(destination_valid), 64'(m_mask));
    check_output("avail", 64'(c2n_network_available), 64'(exp_avail));
    c2n_message_out_valid = '0;
  endtask

  // Present a message tagged with its channel number in the top byte
  task automatic set_enq(input int ch);
    c2n_message_out[ch]       = {8'(ch), 24'($urandom)};
    c2n_destination_valid[ch] = 16'($urandom);
    c2n_message_out_valid[ch] = 1'b1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    apply_stimulus();
    reset = 1'b0;
  endtask

  task automatic preload(input logic [NC-1:0] chans);
    network_available = 1'b0;
    for (int n = 0; n < DEPTH; n++) begin
      for (int i = 0; i < NC; i++) if (chans[i]) set_enq(i);
      apply_stimulus();
    end
  endtask

  task automatic check_obs(input string tag, input int idx, input int expected);
    check_output($sformatf("%s_%0d", tag, idx), 64'((idx < obs.size()) ? obs[idx] : 255), 64'(expected));
  endtask

  int               burst_exp [10] = '{0, 0, 1, 2, 2, 2, 0, 0, 1, 2};
  service_message_t saved_msg;
  tile_mask_t       saved_mask;

  initial begin
    reset                 = 1'b1;
    network_available     = 1'b0;
    c2n_message_out       = '0;
    c2n_destination_valid = '0;
    c2n_message_out_valid = '0;
    channel_weight        = {3'd3, 3'd1, 3'd2};

    // Reset state
    apply_stimulus();
    apply_stimulus();
    reset = 1'b0;
    check_output("reset_valid", 64'(message_out_valid), 64'd0);
    check_output("reset_message", 64'(message_out), 64'd0);
    check_output("reset_avail", 64'(c2n_network_available), 64'(3'b111));

    // Single message on ch1: valid two cycles after the enqueue cycle
    network_available = 1'b1;
    apply_stimulus();
    set_enq(1);
    saved_msg  = c2n_message_out[1];
    saved_mask = c2n_destination_valid[1];
    apply_stimulus();
    check_output("single_t1_valid", 64'(message_out_valid), 64'd0);
    apply_stimulus();
    check_output("single_t2_valid", 64'(message_out_valid), 64'd1);
    check_output("single_t2_msg", 64'(message_out), 64'(saved_msg));
    check_output("single_t2_mask", 64'(destination_valid), 64'(saved_mask));
    apply_stimulus();

    // Weighted bursts with weights {2,1,3}
    do_reset();
    preload(3'b111);
    network_available = 1'b1;
    obs.delete();
    repeat (16) apply_stimulus();
    for (int i = 0; i < 10; i++) check_obs("burst", i, burst_exp[i]);
    check_output("burst_total", 64'(obs.size()), 64'd12);

    // Weight zero on ch0 alternates with ch1
    do_reset();
    channel_weight = {3'd3, 3'd1, 3'd0};
    preload(3'b011);
    network_available = 1'b1;
    obs.delete();
    repeat (10) apply_stimulus();
    for (int i = 0; i < 8; i++) check_obs("wzero", i, i % 2);

    // Backpressure mid-burst on ch2 with one credit remaining
    do_reset();
    channel_weight = {3'd3, 3'd1, 3'd2};
    preload(3'b111);
    network_available = 1'b1;
    repeat (5) apply_stimulus();
    network_available = 1'b0;
    apply_stimulus();
    obs.delete();
    repeat (4) apply_stimulus();
    check_output("bp_no_valid", 64'(obs.size()), 64'd0);
    network_available = 1'b1;
    repeat (3) apply_stimulus();
    check_obs("bp_resume", 0, 2);
    check_obs("bp_resume", 1, 0);
    repeat (10) apply_stimulus();

    // Availability threshold on ch0 while the VN is blocked
    do_reset();
    network_available = 1'b0;
    set_enq(0);
    apply_stimulus();
    check_output("thr_after1", 64'(c2n_network_available[0]), 64'd1);
    set_enq(0);
    apply_stimulus();
    check_output("thr_after2", 64'(c2n_network_available[0]), 64'd0);
    set_enq(0);
    apply_stimulus();
    set_enq(0);
    apply_stimulus();
    network_available = 1'b1;
    obs.delete();
    repeat (6) apply_stimulus();
    check_output("thr_drained", 64'(obs.size()), 64'd4);
    check_output("thr_avail_back", 64'(c2n_network_available), 64'(3'b111));

    // Reset in the middle of a burst discards everything
    do_reset();
    preload(3'b111);
    network_available = 1'b1;
    repeat (2) apply_stimulus();
    do_reset();
    check_output("midrst_valid", 64'(message_out_valid), 64'd0);
    apply_stimulus();
    check_output("midrst_next_valid", 64'(message_out_valid), 64'd0);
    check_output("midrst_avail", 64'(c2n_network_available), 64'(3'b111));

`ifdef C2N_SCHED_STATS_EN
    // Ten issues on ch1
    do_reset();
    network_available = 1'b1;
    for (int n = 0; n < 10; n++) begin
      set_enq(1);
      apply_stimulus();
    end
    repeat (3) apply_stimulus();
    check_output("stats_ch1", 64'(issue_count[1]), 64'd10);
    check_output("stats_ch0", 64'(issue_count[0]), 64'd0);
`endif

    // Randomized traffic, backpressure, weight changes and occasional resets
    do_reset();
    for (int n = 0; n < 400; n++) begin
      reset             = ($urandom_range(0, 59) == 0);
      network_available = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 19) == 0) channel_weight = 9'($urandom);
      for (int i = 0; i < NC; i++) begin
        if ($urandom_range(0, 1) == 1 && mq[i].size() < DEPTH) set_enq(i);
      end
      apply_stimulus();
    end
    reset = 1'b0;
`ifdef C2N_SCHED_STATS_EN
    for (int i = 0; i < NC; i++)
      check_output($sformatf("rand_stats_%0d", i), 64'(issue_count[i]), 64'(m_issues[i]));
`endif

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
